// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } vend_state_t;

    localparam int COIN5       = 5;
    localparam int COIN10      = 10;
    localparam int CHANGE_UNIT = 5;

    // Width of the shared hold/gap timer; covers any sensible dispense or gap length.
    localparam int TIMER_W = 8;

endpackage

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable down-counter with a done flag
import vend_pkg::*;

module vend_timer #(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - credit keeping, product dispense and change return sequencer
import vend_pkg::*;

module vend_controller #(
    parameter int PRICE_A         = 15,
    parameter int PRICE_B         = 20,
    parameter int MAX_CREDIT      = 40,
    parameter int CREDIT_W        = 6,
    parameter int DISPENSE_CYCLES = 4,
    parameter int CHANGE_GAP      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin5_p,
    input  logic                coin10_p,
    input  logic                sel_a_p,
    input  logic                sel_b_p,
    input  logic                cancel_p,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_a,
    output logic                dispense_b,
    output logic                change_5,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] P_A   = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] P_B   = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W:0]   MAXC  = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] C5    = CREDIT_W'(COIN5);
    localparam logic [CREDIT_W-1:0] C10   = CREDIT_W'(COIN10);
    localparam logic [CREDIT_W-1:0] UNIT  = CREDIT_W'(CHANGE_UNIT);
    // Timer is loaded at the edge that starts a hold/gap, so it reaches zero in its last cycle.
    localparam logic [TIMER_W-1:0]  DISP_LD = TIMER_W'(DISPENSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  GAP_LD  = TIMER_W'(CHANGE_GAP - 1);

    vend_state_t         state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic                prod_b, prod_b_n;
    logic                change_n, reject_n, deny_n;
    logic                tload, tdone;
    logic [TIMER_W-1:0]  tval;
    logic                coin_any;
    logic [CREDIT_W-1:0] coin_sum;
    logic [CREDIT_W:0]   sum_ext;

    assign coin_any = coin5_p | coin10_p;
    assign coin_sum = (coin5_p ? C5 : '0) + (coin10_p ? C10 : '0);
    assign sum_ext  = {1'b0, credit} + {1'b0, coin_sum};

    vend_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tload),
        .load_val (tval),
        .done     (tdone)
    );

    // Next state, next credit and next pulse outputs for the current cycle's events.
    always_comb begin
        state_n  = state;
        credit_n = credit;
        prod_b_n = prod_b;
        change_n = 1'b0;
        reject_n = 1'b0;
        deny_n   = 1'b0;
        tload    = 1'b0;
        tval     = '0;
        case (state)
            COLLECT: begin
                if (cancel_p) begin
                    reject_n = coin_any;
                    if (credit != '0) begin
                        state_n  = CHANGE;
                        change_n = 1'b1;
                        tload    = 1'b1;
                        tval     = GAP_LD;
                    end
                end else if (sel_a_p) begin
                    reject_n = coin_any;
                    if (credit >= P_A) begin
                        credit_n = credit - P_A;
                        state_n  = DISPENSE;
                        prod_b_n = 1'b0;
                        tload    = 1'b1;
                        tval     = DISP_LD;
                    end else begin
                        deny_n = 1'b1;
                    end
                end else if (sel_b_p) begin
                    reject_n = coin_any;
                    if (credit >= P_B) begin
                        credit_n = credit - P_B;
                        state_n  = DISPENSE;
                        prod_b_n = 1'b1;
                        tload    = 1'b1;
                        tval     = DISP_LD;
                    end else begin
                        deny_n = 1'b1;
                    end
                end else if (coin_any) begin
                    if (sum_ext <= MAXC) begin
                        credit_n = credit + coin_sum;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                reject_n = coin_any;
                if (tdone) begin
                    if (credit != '0) begin
                        state_n  = CHANGE;
                        change_n = 1'b1;
                        tload    = 1'b1;
                        tval     = GAP_LD;
                    end else begin
                        state_n = COLLECT;
                    end
                end
            end
            CHANGE: begin
                reject_n = coin_any;
                if (change_5) begin
                    credit_n = credit - UNIT;
                end
                if (change_5 && credit == UNIT) begin
                    state_n = COLLECT;
                end else if (tdone) begin
                    change_n = 1'b1;
                    tload    = 1'b1;
                    tval     = GAP_LD;
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

    // State, credit and every output are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= COLLECT;
            credit      <= '0;
            prod_b      <= 1'b0;
            dispense_a  <= 1'b0;
            dispense_b  <= 1'b0;
            change_5    <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            prod_b      <= prod_b_n;
            dispense_a  <= (state_n == DISPENSE) && !prod_b_n;
            dispense_b  <= (state_n == DISPENSE) && prod_b_n;
            change_5    <= change_n;
            coin_reject <= reject_n;
            deny        <= deny_n;
            busy        <= (state_n != COLLECT);
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - randomized and directed self-checking bench for vend_controller
module tb_vend_controller;

    localparam int PA   = 15;
    localparam int PB   = 20;
    localparam int MAXC = 40;
    localparam int D    = 4;
    localparam int GAP  = 2;
    localparam int N    = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin5_p = 1'b0, coin10_p = 1'b0, sel_a_p = 1'b0, sel_b_p = 1'b0, cancel_p = 1'b0;
    logic [5:0] credit;
    logic       dispense_a, dispense_b, change_5, coin_reject, deny, busy;
    logic [11:0] obs;

    int n_pass = 0;
    int n_total = 0;

    // Expected outputs after each modelled edge.
    int e_cr[N];
    bit e_da[N], e_db[N], e_ch[N], e_rj[N], e_dn[N], e_bz[N];
    int m_credit = 0;
    int free_edge = 0;
    int cur_e = 0;
    int last_e = 0;

    vend_controller dut (
        .clk         (clk),
        .reset       (reset),
        .coin5_p     (coin5_p),
        .coin10_p    (coin10_p),
        .sel_a_p     (sel_a_p),
        .sel_b_p     (sel_b_p),
        .cancel_p    (cancel_p),
        .credit      (credit),
        .dispense_a  (dispense_a),
        .dispense_b  (dispense_b),
        .change_5    (change_5),
        .coin_reject (coin_reject),
        .deny        (deny),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign obs = {credit, dispense_a, dispense_b, change_5, coin_reject, deny, busy};

    function automatic logic [11:0] expv(input int x);
        return {6'(e_cr[x]), e_da[x], e_db[x], e_ch[x], e_rj[x], e_dn[x], e_bz[x]};
    endfunction

    function automatic void set_idle(input int x, input int c);
        e_cr[x] = c; e_da[x] = 0; e_db[x] = 0; e_ch[x] = 0;
        e_rj[x] = 0; e_dn[x] = 0; e_bz[x] = 0;
    endfunction

    // Change return: credit/5 pulses every GAP edges from s; returns the first idle edge.
    function automatic int fill_change(input int s, input int c);
        int cur = c;
        int last = s + GAP * (c / 5 - 1);
        for (int x = s; x <= last + 1; x++) begin
            set_idle(x, cur);
            e_bz[x] = (x <= last);
            if (x <= last && (x - s) % GAP == 0) begin
                e_ch[x] = 1;
                cur -= 5;
            end
        end
        return last + 1;
    endfunction

    function automatic int fill_dispense(input int s, input bit is_b, input int rem);
        for (int x = s; x < s + D; x++) begin
            set_idle(x, rem);
            e_da[x] = !is_b;
            e_db[x] = is_b;
            e_bz[x] = 1;
        end
        if (rem > 0) return fill_change(s + D, rem);
        set_idle(s + D, 0);
        return s + D;
    endfunction

    function automatic void model_edge(input int e, input bit c5, input bit c10,
                                       input bit sa, input bit sb, input bit cn);
        int s;
        if (e < free_edge) begin
            e_rj[e] = c5 | c10;
            return;
        end
        set_idle(e, m_credit);
        s = (c5 ? 5 : 0) + (c10 ? 10 : 0);
        if (cn) begin
            if (m_credit > 0) begin
                free_edge = fill_change(e, m_credit) + 1;
                m_credit = 0;
            end
        end else if (sa) begin
            if (m_credit >= PA) begin
                free_edge = fill_dispense(e, 0, m_credit - PA) + 1;
                m_credit = 0;
            end else e_dn[e] = 1;
        end else if (sb) begin
            if (m_credit >= PB) begin
                free_edge = fill_dispense(e, 1, m_credit - PB) + 1;
                m_credit = 0;
            end else e_dn[e] = 1;
        end else if (s > 0) begin
            if (m_credit + s <= MAXC) begin
                m_credit += s;
                e_cr[e] = m_credit;
            end else e_rj[e] = 1;
        end
        if ((cn | sa | sb) && (c5 | c10)) e_rj[e] = 1;
    endfunction

    task automatic step(input bit c5, input bit c10, input bit sa, input bit sb, input bit cn);
        coin5_p = c5; coin10_p = c10; sel_a_p = sa; sel_b_p = sb; cancel_p = cn;
        @(posedge clk);
        model_edge(cur_e, c5, c10, sa, sb, cn);
        last_e = cur_e;
        cur_e++;
        @(negedge clk);
        coin5_p = 0; coin10_p = 0; sel_a_p = 0; sel_b_p = 0; cancel_p = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        repeat (2) @(negedge clk);
        n_total++;
        if (obs !== 12'h000) $display("FAIL reset_state: got %h want %h", obs, 12'h000);
        else n_pass++;
        reset = 1;
        m_credit = 0;
        free_edge = cur_e;
    endtask

    task automatic test_purchase_exact;
        int cnt = 0;
        step(0, 1, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL exact_coin10: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL exact_coin5: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(0, 0, 1, 0, 0);
        cnt += dispense_a;
        for (int i = 0; i < 7; i++) begin
            n_total++;
            if (obs !== expv(last_e)) $display("FAIL exact_dispense[%0d]: got %h want %h", i, obs, expv(last_e));
            else n_pass++;
            step(0, 0, 0, 0, 0);
            cnt += dispense_a;
        end
        n_total++;
        if (cnt !== D || busy !== 1'b0 || credit !== 6'd0)
            $display("FAIL exact_summary: got cnt=%0d busy=%0b credit=%0d want %0d/0/0", cnt, busy, credit, D);
        else n_pass++;
    endtask

    task automatic test_purchase_change;
        int cnt = 0;
        repeat (3) step(0, 1, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL change_credit30: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 13; i++) begin
            cnt += change_5;
            n_total++;
            if (obs !== expv(last_e)) $display("FAIL change_seq[%0d]: got %h want %h", i, obs, expv(last_e));
            else n_pass++;
            step(0, 0, 0, 0, 0);
        end
        n_total++;
        if (cnt !== 3) $display("FAIL change_count: got %0d want 3", cnt);
        else n_pass++;
    endtask

    task automatic test_overflow;
        repeat (3) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL ovf_credit35: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(0, 1, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL ovf_reject10: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL ovf_fill40: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL ovf_reject5: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            n_total++;
            if (obs !== expv(last_e)) $display("FAIL ovf_drain[%0d]: got %h want %h", i, obs, expv(last_e));
            else n_pass++;
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_deny_cancel;
        int cnt = 0;
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL deny_and_reject: got %h want %h", obs, expv(last_e));
        else n_pass++;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cnt += change_5;
            n_total++;
            if (obs !== expv(last_e)) $display("FAIL cancel_seq[%0d]: got %h want %h", i, obs, expv(last_e));
            else n_pass++;
            step(0, 0, 0, 0, 0);
        end
        n_total++;
        if (cnt !== 2) $display("FAIL cancel_count: got %0d want 2", cnt);
        else n_pass++;
    endtask

    task automatic test_busy_inputs;
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (obs !== expv(last_e)) $display("FAIL busy_seq[%0d]: got %h want %h", i, obs, expv(last_e));
            else n_pass++;
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset_mid_dispense;
        repeat (2) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e)) $display("FAIL rst_pre: got %h want %h", obs, expv(last_e));
        else n_pass++;
        reset = 0;
        #1;
        n_total++;
        if (obs !== 12'h000) $display("FAIL rst_async: got %h want %h", obs, 12'h000);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (obs !== 12'h000) $display("FAIL rst_hold: got %h want %h", obs, 12'h000);
        else n_pass++;
        reset = 1;
        m_credit = 0;
        free_edge = cur_e;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (obs !== expv(last_e) || credit !== 6'd5) $display("FAIL rst_after: got %h want %h", obs, expv(last_e));
        else n_pass++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            n_total++;
            if (obs !== expv(last_e)) $display("FAIL random[%0d]: got %h want %h", i, obs, expv(last_e));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_purchase_exact();
        test_purchase_change();
        test_overflow();
        test_deny_cancel();
        test_busy_inputs();
        test_reset_mid_dispense();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
